mdu_sequencer: RTL and testbench

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

---
 rtl/mdu_sequencer.sv | 94 +++++++++
 tb/tb_mdu_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide unit for the execute stage: 32-cycle shift-add
// multiply or restoring divide, with pipeline stall, flush and done handshake.
module mdu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        StartE,
  input  logic [1:0]  MDUOpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        FlushE,
  output logic        StallE,
  output logic        DoneE,
  output logic [31:0] MDUResultE,
  output logic        BusyE
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_next;
  logic [4:0]  cnt;
  logic [1:0]  op;
  logic [31:0] opa, opb;
  logic [63:0] acc, acc_step;
  logic [31:0] addend, step_result, dbz_result;
  logic [32:0] mul_sum, div_shift, div_trial;
  logic        div_ok, accept, div_zero, last_cycle;

  assign accept     = (state == IDLE) && StartE && !FlushE;
  assign div_zero   = MDUOpE[1] && (SrcBE == '0);
  assign last_cycle = (cnt == 5'd31);

  // acc holds {product hi, multiplier/product lo} for multiply and
  // {remainder, dividend/quotient} for divide.
  always_comb begin
    addend    = acc[0] ? opa : '0;
    mul_sum   = {1'b0, acc[63:32]} + {1'b0, addend};
    div_shift = acc[63:31];
    div_trial = div_shift - {1'b0, opb};
    // A shifted remainder >= 2^32 always exceeds the divisor; otherwise the
    // trial's top bit is the borrow.
    div_ok    = div_shift[32] || !div_trial[32];
    if (op[1])
      acc_step = div_ok ? {div_trial[31:0], acc[30:0], 1'b1} : {acc[62:0], 1'b0};
    else
      acc_step = {mul_sum, acc[31:1]};
    step_result = op[0] ? acc_step[63:32] : acc_step[31:0];
    dbz_result  = MDUOpE[0] ? SrcAE : '1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = div_zero ? DONE : RUN;
      RUN: begin
        if (FlushE)          state_next = IDLE;
        else if (last_cycle) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign StallE = rst && (accept || (state == RUN));
  assign BusyE  = (state == RUN);
  assign DoneE  = (state == DONE) && !FlushE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      op         <= '0;
      opa        <= '0;
      opb        <= '0;
      acc        <= '0;
      MDUResultE <= '0;
    end else if (accept) begin
      op  <= MDUOpE;
      opa <= SrcAE;
      opb <= SrcBE;
      cnt <= '0;
      acc <= MDUOpE[1] ? {32'b0, SrcAE} : {32'b0, SrcBE};
      if (div_zero) MDUResultE <= dbz_result;
    end else if ((state == RUN) && !FlushE) begin
      acc <= acc_step;
      cnt <= cnt + 5'd1;
      if (last_cycle) MDUResultE <= step_result;
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed vector table, random ops
// against an arithmetic reference model, and flush/reset/hold sequences.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        StartE;
  logic [1:0]  MDUOpE;
  logic [31:0] SrcAE, SrcBE;
  logic        FlushE;
  logic        StallE, DoneE, BusyE;
  logic [31:0] MDUResultE;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_res;

  mdu_sequencer dut (
    .clk(clk), .rst(rst), .StartE(StartE), .MDUOpE(MDUOpE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .FlushE(FlushE), .StallE(StallE),
    .DoneE(DoneE), .MDUResultE(MDUResultE), .BusyE(BusyE)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] b);
    return (op[1] && b == 0) ? 1 : 33;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input bit hold_start);
    int lat, stall_cnt, busy_cnt, extra_done;
    bit got;
    @(negedge clk);
    StartE = 1'b1; MDUOpE = op; SrcAE = a; SrcBE = b; FlushE = 1'b0;
    #1;
    stall_cnt = int'(StallE);
    busy_cnt  = int'(BusyE);
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      if (!hold_start) StartE = 1'b0;
      SrcAE = $urandom; SrcBE = $urandom;
      @(negedge clk);
      lat++;
      if (DoneE) begin
        got = 1'b1;
        check({tag, "_result"}, MDUResultE, exp_res);
        check({tag, "_stall_in_done"}, StallE, 1'b0);
        check({tag, "_busy_in_done"}, BusyE, 1'b0);
        StartE = 1'b0;
      end else begin
        stall_cnt += int'(StallE);
        busy_cnt  += int'(BusyE);
      end
    end
    StartE = 1'b0;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_stall_cycles"}, stall_cnt, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_lat - 1);
    @(negedge clk);
    check({tag, "_done_single"}, DoneE, 1'b0);
    check({tag, "_result_hold"}, MDUResultE, exp_res);
    check({tag, "_no_reaccept"}, BusyE, 1'b0);
    if (hold_start) begin
      extra_done = 0;
      for (int i = 0; i < 36; i++) begin
        @(negedge clk);
        extra_done += int'(DoneE);
      end
      check({tag, "_extra_done"}, extra_done, 0);
    end
    last_res = exp_res;
  endtask

  initial begin
    int done_cnt;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    vecs[0]  = '{2'd0, 32'd7,          32'd6,          32'h0000_002A, 33};
    vecs[1]  = '{2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 33};
    vecs[2]  = '{2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, 33};
    vecs[3]  = '{2'd2, 32'd100,        32'd7,          32'h0000_000E, 33};
    vecs[4]  = '{2'd3, 32'd100,        32'd7,          32'h0000_0002, 33};
    vecs[5]  = '{2'd2, 32'd5,          32'd0,          32'hFFFF_FFFF, 1};
    vecs[6]  = '{2'd3, 32'd5,          32'd0,          32'h0000_0005, 1};
    vecs[7]  = '{2'd2, 32'hFFFF_FFFF,  32'h8000_0001,  32'h0000_0001, 33};
    vecs[8]  = '{2'd3, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE, 33};
    vecs[9]  = '{2'd1, 32'h8000_0000,  32'd2,          32'h0000_0001, 33};
    vecs[10] = '{2'd2, 32'd0,          32'd3,          32'h0000_0000, 33};
    vecs[11] = '{2'd3, 32'h1234_5678,  32'd1,          32'h0000_0000, 33};

    // Reset with StartE high: stall must stay low while in reset.
    rst = 1'b0; StartE = 1'b1; FlushE = 1'b0; MDUOpE = 2'd0; SrcAE = 32'd3; SrcBE = 32'd4;
    #3;
    check("reset_stall", StallE, 1'b0);
    check("reset_done", DoneE, 1'b0);
    check("reset_busy", BusyE, 1'b0);
    check("reset_result", MDUResultE, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; StartE = 1'b0;

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'd0;
      else if ($urandom_range(0, 3) == 0) rb = $urandom_range(1, 15);
      run_op($sformatf("rnd%0d", i), rop, ra, rb, ref_result(rop, ra, rb), ref_latency(rop, rb), 1'b0);
    end

    // StartE held through DONE, normal and divide-by-zero.
    run_op("hold_mul", 2'd0, 32'd3, 32'd4, 32'd12, 33, 1'b1);
    run_op("hold_dbz", 2'd3, 32'd9, 32'd0, 32'd9, 1, 1'b1);

    // Flush at RUN cycle 10.
    @(negedge clk);
    StartE = 1'b1; MDUOpE = 2'd0; SrcAE = 32'd3; SrcBE = 32'd5;
    @(posedge clk); #1 StartE = 1'b0;
    for (int i = 0; i < 10; i++) @(posedge clk);
    #1 FlushE = 1'b1;
    @(negedge clk);
    check("flush_run_busy", BusyE, 1'b1);
    check("flush_run_done", DoneE, 1'b0);
    @(posedge clk); #1 FlushE = 1'b0;
    check("flush_after_busy", BusyE, 1'b0);
    check("flush_after_stall", StallE, 1'b0);
    check("flush_after_result", MDUResultE, last_res);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      done_cnt += int'(DoneE);
    end
    check("flush_no_done", done_cnt, 0);
    check("flush_result_kept", MDUResultE, last_res);

    // Flush beats StartE in IDLE.
    @(negedge clk);
    StartE = 1'b1; FlushE = 1'b1; MDUOpE = 2'd2; SrcAE = 32'd50; SrcBE = 32'd5;
    #1 check("flush_idle_stall", StallE, 1'b0);
    @(posedge clk); #1 StartE = 1'b0; FlushE = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", BusyE, 1'b0);
    check("flush_idle_done", DoneE, 1'b0);

    // Flush during the DONE cycle suppresses the pulse.
    @(negedge clk);
    StartE = 1'b1; MDUOpE = 2'd2; SrcAE = 32'd9; SrcBE = 32'd0;
    @(posedge clk); #1 StartE = 1'b0; FlushE = 1'b1;
    @(negedge clk);
    check("flush_done_pulse", DoneE, 1'b0);
    @(posedge clk); #1 FlushE = 1'b0;
    @(negedge clk);
    check("flush_done_after", DoneE, 1'b0);
    check("flush_done_busy", BusyE, 1'b0);

    // Asynchronous reset mid-RUN.
    run_op("pre_reset", 2'd0, 32'h1234, 32'h10, 32'h0001_2340, 33, 1'b0);
    @(negedge clk);
    StartE = 1'b1; MDUOpE = 2'd0; SrcAE = 32'd11; SrcBE = 32'd13;
    @(posedge clk); #1 StartE = 1'b0;
    for (int i = 0; i < 5; i++) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b0; StartE = 1'b1;
    #1;
    check("arst_stall", StallE, 1'b0);
    check("arst_busy", BusyE, 1'b0);
    check("arst_done", DoneE, 1'b0);
    check("arst_result", MDUResultE, 32'd0);
    @(posedge clk); #1 rst = 1'b1; StartE = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      done_cnt += int'(DoneE);
    end
    check("arst_no_done", done_cnt, 0);
    run_op("post_reset", 2'd2, 32'd100, 32'd7, 32'd14, 33, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
